l1_data_fill_ctrl: RTL and testbench
====================================

Name: l1_data_fill_ctrl

Overview:
- Direct-mapped lookup and fill controller sitting directly upstream of the L1 data register file (32 x 16-bit words, 5-bit address, mode 0 = read, 1 = write).
- Owns the tag/valid store and accepts CPU loads and stores.
- On a read miss it fetches the whole line from the next-level memory over a req/ack handshake and streams each word into the L1 array through its write port.
- Stores are write-through, no-write-allocate.

Parameters:
- ADDR_W, 16, CPU word-address width.
- DATA_W, 16, data word width; must match the L1 array width.
- LINE_WORDS, 4, words per line (power of 2, 2..16); lines = 32/LINE_WORDS; offset = log2(LINE_WORDS) bits; index = 5 - offset bits; tag = ADDR_W - 5 bits.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_req  input  1  request strobe; sampled only when cpu_busy=0.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_addr  input  ADDR_W  word address.
- cpu_wdata  input  DATA_W  store data.
- cpu_busy  output  1  high from the cycle after acceptance through the cpu_ready cycle.
- cpu_ready  output  1  one-cycle completion pulse.
- cpu_rdata  output  DATA_W  load data, valid when cpu_ready=1 and the request was a load.
- l1_mode  output  1  L1 mode (1 = write this cycle).
- l1_waddr  output  5  L1 write address.
- l1_wdata  output  DATA_W  L1 write data.
- l1_raddr  output  5  L1 read address.
- l1_rdata  input  DATA_W  L1 combinational read data.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  memory write (1) / read (0).
- mem_addr  output  ADDR_W  memory word address.
- mem_wdata  output  DATA_W  memory write data.
- mem_ack  input  1  one-cycle completion; mem_rdata valid on reads in the same cycle.
- mem_rdata  input  DATA_W  memory read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all valid bits=0.
  - cpu_busy, cpu_ready, mem_req, mem_we, l1_mode=0.
  - cpu_rdata, mem_addr, mem_wdata, l1_waddr, l1_wdata, l1_raddr=0.
  - Tags are not reset.
- Address split: tag=cpu_addr[ADDR_W-1:5], index=cpu_addr[4:off], offset=cpu_addr[off-1:0]; L1 word address=cpu_addr[4:0].
- States: IDLE, LOOKUP, FILL, WRITE, DONE.
- IDLE:
  - cpu_req=1 latches addr/we/wdata into request registers; cpu_busy=1 next cycle; goes to LOOKUP.
- LOOKUP:
  - l1_raddr=req_addr[4:0]; hit = valid[index] & (tag_store[index]==req_tag).
  - Load hit: cpu_rdata<=l1_rdata, cpu_ready<=1, go to DONE. Read-hit latency: cpu_ready is high 2 cycles after the cpu_req sample edge.
  - Load miss: go to FILL with fill_cnt=0; valid[index]<=0.
  - Store (hit or miss): record hit, go to WRITE.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={req_tag, index, fill_cnt}.
  - On mem_ack: l1_mode=1 combinationally that cycle, l1_waddr={index, fill_cnt}, l1_wdata=mem_rdata.
  - If fill_cnt==req offset, capture mem_rdata into cpu_rdata.
  - fill_cnt increments on each ack. mem_req may stay high across consecutive words.
  - On the last word's ack: tag_store[index]<=req_tag, valid[index]<=1, cpu_ready<=1, go to DONE.
  - Miss latency = sum of ack waits + 2 cycles.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=req_addr, mem_wdata=req_wdata.
  - On mem_ack: if hit, l1_mode=1 with l1_waddr=req_addr[4:0] and l1_wdata=req_wdata that cycle. A store miss never touches L1 or the tags.
  - cpu_ready<=1, go to DONE.
- DONE:
  - cpu_ready=1 for exactly one cycle; cpu_busy drops next cycle; returns to IDLE.
  - cpu_req is honoured again in the IDLE cycle after DONE.
- l1_mode=0 in every cycle except the write cycles defined above.
- Boundary conditions:
  - cpu_req while cpu_busy=1 is ignored, with no queueing.
  - mem_ack outside FILL/WRITE, or with mem_req=0, is ignored.
  - fill_cnt wraps naturally at LINE_WORDS; the FSM exits before the wrap.
  - Address-bit aliasing above ADDR_W does not occur, because widths are exact.
  - Reset mid-FILL: the line stays invalid and mem_req drops asynchronously. Memory must discard an abandoned request.
  - Conflict miss: the line is overwritten, with no writeback needed because the cache is write-through.

Test Plan:
- After reset, load addr 0x0012 with memory returning 0xA000+word on ack after 1 cycle -> 4 mem reads at 0x0010..0x0013, L1 writes at 0x10..0x13, cpu_rdata=0xA012, then a repeat load of 0x0013 hits -> cpu_ready 2 cycles after request, cpu_rdata=0xA013, no mem_req.
- Store 0xBEEF to 0x0011 (hit) -> mem write to 0x0011 with data 0xBEEF, L1 write at 0x11 in the ack cycle; a following load of 0x0011 hits and returns 0xBEEF.
- Store 0x1234 to 0x0420 (miss) -> mem write only, l1_mode stays 0; a following load of 0x0420 misses and fills.
- Conflict: load 0x0012, then load 0x0032 (same index, different tag) -> refill of 0x0030..0x0033; load 0x0012 again misses.
- Drive cpu_req every cycle during a fill with 3-cycle ack delays -> exactly one transaction is accepted and cpu_ready pulses exactly once.
- Assert reset after the 2nd fill word -> mem_req=0 immediately; after release, a load of the same address misses and performs a full 4-word fill.

Source files
------------

// File: rtl/l1_data_fill_ctrl_if.sv
// Bus bundles for the L1 data fill controller: CPU request port, L1 register-file port,
// and next-level memory port. The controller is the slave of the CPU bus and master of the other two.

interface l1_cpu_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_busy;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_busy, cpu_ready, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_busy, cpu_ready, cpu_rdata
    );
endinterface

interface l1_array_if #(
    parameter int DATA_W = 16
);
    logic              l1_mode;
    logic [4:0]        l1_waddr;
    logic [DATA_W-1:0] l1_wdata;
    logic [4:0]        l1_raddr;
    logic [DATA_W-1:0] l1_rdata;

    modport master (
        output l1_mode, l1_waddr, l1_wdata, l1_raddr,
        input  l1_rdata
    );

    modport slave (
        input  l1_mode, l1_waddr, l1_wdata, l1_raddr,
        output l1_rdata
    );
endinterface

interface l1_mem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/l1_data_fill_ctrl.sv
// Direct-mapped tag/valid lookup and line-fill controller in front of a 32-word L1 data array.
// Loads miss into a whole-line fill from next-level memory; stores are write-through, no-write-allocate.

module l1_data_fill_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic       clk,
    input  logic       reset,
    l1_cpu_if.slave    cpu,
    l1_array_if.master l1,
    l1_mem_if.master   mem
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = 5 - OFF_W;
    localparam int TAG_W = ADDR_W - 5;
    localparam int LINES = 32 / LINE_WORDS;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [ADDR_W-1:0] reqAddr;
    logic              reqWe;
    logic [DATA_W-1:0] reqWdata;
    logic              reqHit;

    logic [TAG_W-1:0]  tagStore [LINES];
    logic [LINES-1:0]  validBits;
    logic [OFF_W-1:0]  fillCnt;
    logic [DATA_W-1:0] cpuRdata;

    logic [TAG_W-1:0]  reqTag;
    logic [IDX_W-1:0]  reqIdx;
    logic [OFF_W-1:0]  reqOff;
    logic              hit;
    logic              lastWord;
    logic              accept;

    logic              memReq;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              l1Mode;
    logic [4:0]        l1Waddr;
    logic [DATA_W-1:0] l1Wdata;
    logic [4:0]        l1Raddr;

    assign reqTag   = reqAddr[ADDR_W-1:5];
    assign reqIdx   = reqAddr[4:OFF_W];
    assign reqOff   = reqAddr[OFF_W-1:0];
    assign hit      = validBits[reqIdx] && (tagStore[reqIdx] == reqTag);
    assign lastWord = (fillCnt == LAST_WORD);
    assign accept   = (state == IDLE) && cpu.cpu_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        memReq    = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWdata  = '0;
        l1Mode    = 1'b0;
        l1Waddr   = '0;
        l1Wdata   = '0;
        l1Raddr   = '0;
        case (state)
            IDLE: begin
                if (cpu.cpu_req) begin
                    stateNext = LOOKUP;
                end
            end
            LOOKUP: begin
                l1Raddr = reqAddr[4:0];
                if (reqWe) begin
                    stateNext = WRITE;
                end else if (hit) begin
                    stateNext = DONE;
                end else begin
                    stateNext = FILL;
                end
            end
            FILL: begin
                memReq  = 1'b1;
                memAddr = {reqTag, reqIdx, fillCnt};
                if (mem.mem_ack) begin
                    // Each returning word goes straight into the array in its ack cycle
                    l1Mode  = 1'b1;
                    l1Waddr = {reqIdx, fillCnt};
                    l1Wdata = mem.mem_rdata;
                    if (lastWord) begin
                        stateNext = DONE;
                    end
                end
            end
            WRITE: begin
                memReq   = 1'b1;
                memWe    = 1'b1;
                memAddr  = reqAddr;
                memWdata = reqWdata;
                if (mem.mem_ack) begin
                    if (reqHit) begin
                        l1Mode  = 1'b1;
                        l1Waddr = reqAddr[4:0];
                        l1Wdata = reqWdata;
                    end
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Valid bits, fill counter and load data; a reset mid-fill leaves the line invalid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validBits <= '0;
            fillCnt   <= '0;
            cpuRdata  <= '0;
        end else begin
            case (state)
                LOOKUP: begin
                    if (!reqWe) begin
                        if (hit) begin
                            cpuRdata <= l1.l1_rdata;
                        end else begin
                            validBits[reqIdx] <= 1'b0;
                            fillCnt           <= '0;
                        end
                    end
                end
                FILL: begin
                    if (mem.mem_ack) begin
                        fillCnt <= fillCnt + OFF_W'(1);
                        if (fillCnt == reqOff) begin
                            cpuRdata <= mem.mem_rdata;
                        end
                        if (lastWord) begin
                            validBits[reqIdx] <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Request registers and tags carry no reset: they are only read once qualified by state/valid
    always_ff @(posedge clk) begin
        if (accept) begin
            reqAddr  <= cpu.cpu_addr;
            reqWe    <= cpu.cpu_we;
            reqWdata <= cpu.cpu_wdata;
        end
        if (state == LOOKUP) begin
            reqHit <= hit;
        end
        if ((state == FILL) && mem.mem_ack && lastWord) begin
            tagStore[reqIdx] <= reqTag;
        end
    end

    assign cpu.cpu_busy  = (state != IDLE);
    assign cpu.cpu_ready = (state == DONE);
    assign cpu.cpu_rdata = cpuRdata;

    assign mem.mem_req   = memReq;
    assign mem.mem_we    = memWe;
    assign mem.mem_addr  = memAddr;
    assign mem.mem_wdata = memWdata;

    assign l1.l1_mode    = l1Mode;
    assign l1.l1_waddr   = l1Waddr;
    assign l1.l1_wdata   = l1Wdata;
    assign l1.l1_raddr   = l1Raddr;

endmodule

// File: tb/tb_l1_data_fill_ctrl.sv
// Scoreboard bench for l1_data_fill_ctrl with an L1 array model and a next-level memory model
// whose ack delay is programmable.

module tb_l1_data_fill_ctrl;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } memTxn_t;

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
    } l1Txn_t;

    typedef struct {
        logic        isLoad;
        logic [15:0] data;
    } cpuTxn_t;

    logic clk;
    logic rst_n;

    l1_cpu_if   #(.ADDR_W(16), .DATA_W(16)) cpuIf ();
    l1_array_if #(.DATA_W(16))              l1If ();
    l1_mem_if   #(.ADDR_W(16), .DATA_W(16)) memIf ();

    l1_data_fill_ctrl #(
        .ADDR_W(16),
        .DATA_W(16),
        .LINE_WORDS(4)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .cpu(cpuIf),
        .l1(l1If),
        .mem(memIf)
    );

    int checks = 0;
    int failures = 0;

    memTxn_t memQ[$];
    l1Txn_t  l1Q[$];
    cpuTxn_t cpuQ[$];

    logic [15:0] l1Array [32];
    logic [15:0] memStore [logic [15:0]];
    int ackDelay = 1;
    int waitCnt = 0;
    int memAckCnt = 0;
    int readyCnt = 0;
    bit memReqSeen = 0;
    bit l1WriteSeen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // L1 register file: synchronous write, combinational read
    initial begin
        for (int i = 0; i < 32; i++) l1Array[i] = 16'h0000;
        forever begin
            @(posedge clk);
            if (l1If.l1_mode) l1Array[l1If.l1_waddr] = l1If.l1_wdata;
        end
    end
    assign l1If.l1_rdata = l1Array[l1If.l1_raddr];

    // Next-level memory: acks ackDelay cycles after seeing mem_req; unwritten words read 0xA000+addr
    initial begin
        memIf.mem_ack   = 1'b0;
        memIf.mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            memIf.mem_ack = 1'b0;
            if (!rst_n || !memIf.mem_req) begin
                waitCnt = 0;
            end else if (waitCnt < ackDelay) begin
                waitCnt++;
            end else begin
                waitCnt = 0;
                memIf.mem_ack = 1'b1;
                memAckCnt++;
                if (memIf.mem_we) memStore[memIf.mem_addr] = memIf.mem_wdata;
                else if (memStore.exists(memIf.mem_addr)) memIf.mem_rdata = memStore[memIf.mem_addr];
                else memIf.mem_rdata = 16'hA000 + memIf.mem_addr;
            end
        end
    end

    // Monitor: pops expected transactions whenever the DUT presents one
    initial begin
        memTxn_t m;
        l1Txn_t  w;
        cpuTxn_t c;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (memIf.mem_req) memReqSeen = 1;
                if (l1If.l1_mode) begin
                    l1WriteSeen = 1;
                    if (l1Q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL l1_unexpected_write actual addr=%h data=%h required=none", l1If.l1_waddr, l1If.l1_wdata);
                    end else begin
                        w = l1Q.pop_front();
                        check("l1_waddr", 32'(l1If.l1_waddr), 32'(w.addr));
                        check("l1_wdata", 32'(l1If.l1_wdata), 32'(w.data));
                    end
                end
                if (memIf.mem_req && memIf.mem_ack) begin
                    if (memQ.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL mem_unexpected_txn actual addr=%h we=%0d required=none", memIf.mem_addr, memIf.mem_we);
                    end else begin
                        m = memQ.pop_front();
                        check("mem_we", 32'(memIf.mem_we), 32'(m.we));
                        check("mem_addr", 32'(memIf.mem_addr), 32'(m.addr));
                        if (m.we) check("mem_wdata", 32'(memIf.mem_wdata), 32'(m.data));
                    end
                end
                if (cpuIf.cpu_ready) begin
                    readyCnt++;
                    if (cpuQ.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL cpu_unexpected_ready actual=1 required=0");
                    end else begin
                        c = cpuQ.pop_front();
                        if (c.isLoad) check("cpu_rdata", 32'(cpuIf.cpu_rdata), 32'(c.data));
                        check("cpu_busy_at_ready", 32'(cpuIf.cpu_busy), 32'd1);
                    end
                end
            end
        end
    end

    task automatic pushFill(input logic [15:0] base, input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3);
        logic [15:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < 4; i++) begin
            memQ.push_back('{we: 1'b0, addr: base + 16'(i), data: 16'h0000});
            l1Q.push_back('{addr: 5'(base + 16'(i)), data: d[i]});
        end
    endtask

    task automatic pushCpu(input logic isLoad, input logic [15:0] data);
        cpuQ.push_back('{isLoad: isLoad, data: data});
    endtask

    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd);
        cpuIf.cpu_req   = 1'b1;
        cpuIf.cpu_we    = we;
        cpuIf.cpu_addr  = addr;
        cpuIf.cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpuIf.cpu_req = 1'b0;
    endtask

    // Called at a negedge; lat counts negedges after the sample edge until cpu_ready
    task automatic doReq(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                         input bit hold, output int lat);
        cpuIf.cpu_req   = 1'b1;
        cpuIf.cpu_we    = we;
        cpuIf.cpu_addr  = addr;
        cpuIf.cpu_wdata = wd;
        @(posedge clk);
        #1;
        if (!hold) begin
            cpuIf.cpu_req = 1'b0;
        end else begin
            cpuIf.cpu_addr = 16'h0013;
            cpuIf.cpu_we   = 1'b1;
        end
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (cpuIf.cpu_ready) break;
            if (lat >= 300) begin
                check("cpu_ready_timeout", 32'd0, 32'd1);
                break;
            end
        end
        cpuIf.cpu_req = 1'b0;
        cpuIf.cpu_we  = 1'b0;
        @(negedge clk);
        check("busy_after_done", 32'(cpuIf.cpu_busy), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        int base;
        int r0;
        rst_n           = 1'b0;
        cpuIf.cpu_req   = 1'b0;
        cpuIf.cpu_we    = 1'b0;
        cpuIf.cpu_addr  = 16'h0000;
        cpuIf.cpu_wdata = 16'h0000;
        repeat (3) @(negedge clk);

        check("rst_cpu_busy", 32'(cpuIf.cpu_busy), 32'd0);
        check("rst_cpu_ready", 32'(cpuIf.cpu_ready), 32'd0);
        check("rst_cpu_rdata", 32'(cpuIf.cpu_rdata), 32'd0);
        check("rst_mem_req", 32'(memIf.mem_req), 32'd0);
        check("rst_mem_we", 32'(memIf.mem_we), 32'd0);
        check("rst_mem_addr", 32'(memIf.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(memIf.mem_wdata), 32'd0);
        check("rst_l1_mode", 32'(l1If.l1_mode), 32'd0);
        check("rst_l1_waddr", 32'(l1If.l1_waddr), 32'd0);
        check("rst_l1_wdata", 32'(l1If.l1_wdata), 32'd0);
        check("rst_l1_raddr", 32'(l1If.l1_raddr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold load miss then a hit in the same line
        pushFill(16'h0010, 16'hA010, 16'hA011, 16'hA012, 16'hA013);
        pushCpu(1, 16'hA012);
        doReq(0, 16'h0012, 16'h0000, 0, lat);
        check("miss_latency", 32'(lat), 32'd10);
        memReqSeen = 0;
        pushCpu(1, 16'hA013);
        doReq(0, 16'h0013, 16'h0000, 0, lat);
        check("hit_latency", 32'(lat), 32'd2);
        check("hit_no_mem_req", 32'(memReqSeen), 32'd0);

        // Store hit: memory write plus L1 update, then read it back
        memQ.push_back('{we: 1'b1, addr: 16'h0011, data: 16'hBEEF});
        l1Q.push_back('{addr: 5'h11, data: 16'hBEEF});
        pushCpu(0, 16'h0000);
        doReq(1, 16'h0011, 16'hBEEF, 0, lat);
        check("store_latency", 32'(lat), 32'd4);
        memReqSeen = 0;
        pushCpu(1, 16'hBEEF);
        doReq(0, 16'h0011, 16'h0000, 0, lat);
        check("store_hit_readback_lat", 32'(lat), 32'd2);
        check("store_hit_readback_no_mem", 32'(memReqSeen), 32'd0);

        // Store miss: memory only, no allocate
        l1WriteSeen = 0;
        memQ.push_back('{we: 1'b1, addr: 16'h0420, data: 16'h1234});
        pushCpu(0, 16'h0000);
        doReq(1, 16'h0420, 16'h1234, 0, lat);
        check("store_miss_no_l1_write", 32'(l1WriteSeen), 32'd0);
        pushFill(16'h0420, 16'h1234, 16'hA421, 16'hA422, 16'hA423);
        pushCpu(1, 16'h1234);
        doReq(0, 16'h0420, 16'h0000, 0, lat);
        check("store_miss_then_load_lat", 32'(lat), 32'd10);

        // Conflict miss on index 4
        pushCpu(1, 16'hA012);
        doReq(0, 16'h0012, 16'h0000, 0, lat);
        check("conflict_pre_hit_lat", 32'(lat), 32'd2);
        pushFill(16'h0030, 16'hA030, 16'hA031, 16'hA032, 16'hA033);
        pushCpu(1, 16'hA032);
        doReq(0, 16'h0032, 16'h0000, 0, lat);
        check("conflict_fill_lat", 32'(lat), 32'd10);
        pushFill(16'h0010, 16'hA010, 16'hBEEF, 16'hA012, 16'hA013);
        pushCpu(1, 16'hA012);
        doReq(0, 16'h0012, 16'h0000, 0, lat);
        check("conflict_refill_lat", 32'(lat), 32'd10);

        // cpu_req held high through a slow fill: exactly one transaction
        ackDelay = 3;
        r0 = readyCnt;
        pushFill(16'h0008, 16'hA008, 16'hA009, 16'hA00A, 16'hA00B);
        pushCpu(1, 16'hA008);
        doReq(0, 16'h0008, 16'h0000, 1, lat);
        check("held_req_latency", 32'(lat), 32'd18);
        repeat (8) @(negedge clk);
        check("held_req_ready_pulses", 32'(readyCnt - r0), 32'd1);
        check("held_req_idle_busy", 32'(cpuIf.cpu_busy), 32'd0);

        // Reset after the second fill word
        ackDelay = 1;
        memQ.push_back('{we: 1'b0, addr: 16'h0004, data: 16'h0000});
        memQ.push_back('{we: 1'b0, addr: 16'h0005, data: 16'h0000});
        l1Q.push_back('{addr: 5'h04, data: 16'hA004});
        l1Q.push_back('{addr: 5'h05, data: 16'hA005});
        base = memAckCnt;
        @(negedge clk);
        issue(0, 16'h0004, 16'h0000);
        n = 0;
        while ((memAckCnt < base + 2) && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_ack_wait", 32'(n < 100), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midfill_rst_mem_req", 32'(memIf.mem_req), 32'd0);
        check("midfill_rst_busy", 32'(cpuIf.cpu_busy), 32'd0);
        check("midfill_rst_rdata", 32'(cpuIf.cpu_rdata), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pushFill(16'h0004, 16'hA004, 16'hA005, 16'hA006, 16'hA007);
        pushCpu(1, 16'hA004);
        doReq(0, 16'h0004, 16'h0000, 0, lat);
        check("post_reset_refill_lat", 32'(lat), 32'd10);

        repeat (4) @(negedge clk);
        check("memQ_drained", 32'(memQ.size()), 32'd0);
        check("l1Q_drained", 32'(l1Q.size()), 32'd0);
        check("cpuQ_drained", 32'(cpuQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
